// File: rtl/read_stage_if.sv
// rtl/read_stage_if.sv - fetch/execute/write-back bus of the operand-read stage
interface read_stage_if;
    logic [15:0] instruction_in;
    logic        backpressure_exec_load;
    logic        jmp_detected;
    logic        fwd_exec_en;
    logic [2:0]  fwd_exec_dest;
    logic [31:0] fwd_exec_data;
    logic        wb_en;
    logic [2:0]  wb_dest;
    logic [31:0] wb_data;
    logic [79:0] instruction_out;
    logic        stall_fetch;

    modport master (
        output instruction_in, backpressure_exec_load, jmp_detected,
        output fwd_exec_en, fwd_exec_dest, fwd_exec_data,
        output wb_en, wb_dest, wb_data,
        input  instruction_out, stall_fetch
    );

    modport slave (
        input  instruction_in, backpressure_exec_load, jmp_detected,
        input  fwd_exec_en, fwd_exec_dest, fwd_exec_data,
        input  wb_en, wb_dest, wb_data,
        output instruction_out, stall_fetch
    );
endinterface

// File: rtl/read_stage.sv
// rtl/read_stage.sv - register file, operand forwarding and execute packet register
module read_stage (
    input  logic          clk,
    input  logic          rst,
    read_stage_if.slave   bus
);
    localparam int D_SIZE      = 32;
    localparam int I_EXEC_SIZE = 80;

    localparam logic [6:0] OP_NOP      = 7'h00;
    localparam logic [6:0] OP_ADD      = 7'h01;
    localparam logic [6:0] OP_ADDF     = 7'h02;
    localparam logic [6:0] OP_SUB      = 7'h03;
    localparam logic [6:0] OP_SUBF     = 7'h04;
    localparam logic [6:0] OP_AND      = 7'h05;
    localparam logic [6:0] OP_OR       = 7'h06;
    localparam logic [6:0] OP_XOR      = 7'h07;
    localparam logic [6:0] OP_NAND     = 7'h08;
    localparam logic [6:0] OP_NOR      = 7'h09;
    localparam logic [6:0] OP_NXOR     = 7'h0A;
    localparam logic [6:0] OP_SHIFTR   = 7'h0B;
    localparam logic [6:0] OP_SHIFTRA  = 7'h0C;
    localparam logic [6:0] OP_SHIFTL   = 7'h0D;
    localparam logic [6:0] OP_LOAD     = 7'h10;
    localparam logic [6:0] OP_LOADC    = 7'h18;
    localparam logic [6:0] OP_STORE    = 7'h20;
    localparam logic [6:0] OP_JMP      = 7'h28;
    localparam logic [6:0] OP_JMPR     = 7'h30;
    localparam logic [6:0] OP_JMPCOND  = 7'h38;
    localparam logic [6:0] OP_JMPRCOND = 7'h40;
    localparam logic [6:0] OP_HALT     = 7'h7F;

    localparam logic [I_EXEC_SIZE-1:0] NOP_PACKET = {OP_NOP, 3'd0, 3'd0, 3'd0, 64'd0};

    logic [D_SIZE-1:0]      regs [8];
    logic [6:0]             opcode;
    logic [2:0]             op0, op1, op2;
    logic [D_SIZE-1:0]      val0, val1, val2;
    logic [D_SIZE-1:0]      dat1, dat2;
    logic [I_EXEC_SIZE-1:0] packet_q;

    assign {opcode, op0, op1, op2} = bus.instruction_in;

    // Execute result is younger than write-back, so it wins on a shared index.
    function automatic logic [D_SIZE-1:0] resolve(
        input logic [2:0]        idx,
        input logic              fe_en,
        input logic [2:0]        fe_dest,
        input logic [D_SIZE-1:0] fe_data,
        input logic              w_en,
        input logic [2:0]        w_dest,
        input logic [D_SIZE-1:0] w_data,
        input logic [D_SIZE-1:0] rf_val
    );
        if (fe_en && fe_dest == idx)
            return fe_data;
        else if (w_en && w_dest == idx)
            return w_data;
        else
            return rf_val;
    endfunction

    always_comb begin
        val0 = resolve(op0, bus.fwd_exec_en, bus.fwd_exec_dest, bus.fwd_exec_data,
                       bus.wb_en, bus.wb_dest, bus.wb_data, regs[op0]);
        val1 = resolve(op1, bus.fwd_exec_en, bus.fwd_exec_dest, bus.fwd_exec_data,
                       bus.wb_en, bus.wb_dest, bus.wb_data, regs[op1]);
        val2 = resolve(op2, bus.fwd_exec_en, bus.fwd_exec_dest, bus.fwd_exec_data,
                       bus.wb_en, bus.wb_dest, bus.wb_data, regs[op2]);
    end

    always_comb begin
        dat1 = '0;
        dat2 = '0;
        case (opcode)
            OP_ADD, OP_ADDF, OP_SUB, OP_SUBF, OP_AND, OP_OR,
            OP_XOR, OP_NAND, OP_NOR, OP_NXOR: begin
                dat1 = val1;
                dat2 = val2;
            end
            OP_SHIFTR, OP_SHIFTRA, OP_SHIFTL, OP_JMP: begin
                dat1 = val0;
            end
            OP_LOAD: begin
                dat1 = val1;
            end
            OP_STORE, OP_JMPCOND: begin
                dat1 = val0;
                dat2 = val1;
            end
            OP_LOADC, OP_JMPR, OP_JMPRCOND, OP_NOP, OP_HALT: begin
                dat1 = '0;
                dat2 = '0;
            end
            default: begin
                dat1 = '0;
                dat2 = '0;
            end
        endcase
    end

    // Write-back is never blocked by hold or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
        end else if (bus.wb_en) begin
            regs[bus.wb_dest] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            packet_q <= NOP_PACKET;
        else if (!bus.jmp_detected)
            packet_q <= NOP_PACKET;
        else if (bus.backpressure_exec_load)
            packet_q <= {bus.instruction_in, dat1, dat2};
    end

    assign bus.instruction_out = packet_q;
    assign bus.stall_fetch     = !bus.backpressure_exec_load && bus.jmp_detected;
endmodule

// File: tb/tb_read_stage.sv
// tb/tb_read_stage.sv - randomized and directed bench for read_stage
module tb_read_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    read_stage_if bus();

    read_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [6:0] ADD = 7'h01, SUB = 7'h03, OR_ = 7'h06, NXOR = 7'h0A;
    localparam logic [6:0] SHR = 7'h0B, SHL = 7'h0D, LOAD = 7'h10, LOADC = 7'h18;
    localparam logic [6:0] STORE = 7'h20, JMP = 7'h28, JMPR = 7'h30, JMPC = 7'h38;
    localparam logic [6:0] JMPRC = 7'h40, HALT = 7'h7F, NOP = 7'h00;
    localparam logic [79:0] NOP_PKT = 80'd0;

    logic [6:0]  op_table [14] = '{NOP, ADD, SUB, OR_, NXOR, SHR, SHL, LOAD, LOADC,
                                   STORE, JMP, JMPR, JMPC, HALT};
    logic [31:0] mregs [8];
    logic [79:0] exp_out;
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] mk(input logic [6:0] op, input int a, input int b, input int c);
        return {op, 3'(a), 3'(b), 3'(c)};
    endfunction

    // Which instruction field (0..2) feeds each data slot, -1 for a zero slot.
    function automatic int src1(input logic [6:0] op);
        if (op >= 7'h01 && op <= 7'h0A) return 1;
        if (op == LOAD) return 1;
        if (op == JMP || op == JMPC || op == STORE || (op >= 7'h0B && op <= 7'h0D)) return 0;
        return -1;
    endfunction

    function automatic int src2(input logic [6:0] op);
        if (op >= 7'h01 && op <= 7'h0A) return 2;
        if (op == JMPC || op == STORE) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] mval(input logic [2:0] idx);
        if (bus.fwd_exec_en && bus.fwd_exec_dest == idx) return bus.fwd_exec_data;
        if (bus.wb_en && bus.wb_dest == idx) return bus.wb_data;
        return mregs[idx];
    endfunction

    function automatic logic [79:0] model_packet();
        logic [15:0] ins;
        logic [2:0]  f [3];
        logic [31:0] d1, d2;
        int s1, s2;
        ins  = bus.instruction_in;
        f[0] = ins[8:6];
        f[1] = ins[5:3];
        f[2] = ins[2:0];
        s1 = src1(ins[15:9]);
        s2 = src2(ins[15:9]);
        d1 = (s1 < 0) ? 32'd0 : mval(f[s1]);
        d2 = (s2 < 0) ? 32'd0 : mval(f[s2]);
        return {ins, d1, d2};
    endfunction

    task automatic drive(input logic [15:0] ins, input logic fe, input int fd, input logic [31:0] fdat,
                         input logic we, input int wd, input logic [31:0] wdat,
                         input logic bp, input logic jmp);
        bus.instruction_in         = ins;
        bus.fwd_exec_en            = fe;
        bus.fwd_exec_dest          = 3'(fd);
        bus.fwd_exec_data          = fdat;
        bus.wb_en                  = we;
        bus.wb_dest                = 3'(wd);
        bus.wb_data                = wdat;
        bus.backpressure_exec_load = bp;
        bus.jmp_detected           = jmp;
    endtask

    task automatic idle();
        drive(16'd0, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b1);
    endtask

    task automatic cycle();
        logic [79:0] nxt;
        logic        we;
        logic [2:0]  wd;
        logic [31:0] wdat;
        if (!rst) nxt = NOP_PKT;
        else if (!bus.jmp_detected) nxt = NOP_PKT;
        else if (!bus.backpressure_exec_load) nxt = exp_out;
        else nxt = model_packet();
        we = bus.wb_en; wd = bus.wb_dest; wdat = bus.wb_data;
        @(posedge clk);
        if (rst && we) mregs[wd] = wdat;
        #1;
        exp_out = nxt;
    endtask

    task automatic write_reg(input int idx, input logic [31:0] val);
        drive(16'd0, 1'b0, 0, 32'd0, 1'b1, idx, val, 1'b1, 1'b1);
        cycle();
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
        exp_out = NOP_PKT;
        #1;
        checks++;
        if (bus.instruction_out !== NOP_PKT) begin
            errors++; $display("FAIL reset_out got %h want %h", bus.instruction_out, NOP_PKT);
        end
        bus.backpressure_exec_load = 1'b0;
        #1;
        checks++;
        if (bus.stall_fetch !== 1'b1) begin
            errors++; $display("FAIL reset_stall got %b want 1", bus.stall_fetch);
        end
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_write_through();
        write_reg(1, 32'd5);
        write_reg(2, 32'd7);
        drive(mk(ADD, 0, 1, 2), 1'b0, 0, 32'd0, 1'b1, 2, 32'd9, 1'b1, 1'b1);
        cycle();
        checks++;
        if (bus.instruction_out[63:32] !== 32'd5 || bus.instruction_out[31:0] !== 32'd9) begin
            errors++; $display("FAIL write_through got %h_%h want 5_9",
                               bus.instruction_out[63:32], bus.instruction_out[31:0]);
        end
        checks++;
        if (bus.instruction_out !== exp_out) begin
            errors++; $display("FAIL write_through_pkt got %h want %h", bus.instruction_out, exp_out);
        end
    endtask

    task automatic test_fwd_priority();
        drive(mk(SUB, 4, 5, 6), 1'b1, 5, 32'h100, 1'b1, 5, 32'h200, 1'b1, 1'b1);
        cycle();
        checks++;
        if (bus.instruction_out[63:32] !== 32'h100) begin
            errors++; $display("FAIL fwd_priority got %h want 100", bus.instruction_out[63:32]);
        end
        idle();
        cycle();
        checks++;
        if (mregs[5] !== 32'h200) begin
            errors++; $display("FAIL fwd_wb_model got %h want 200", mregs[5]);
        end
    endtask

    task automatic test_load_hold();
        logic [79:0] load_pkt;
        write_reg(1, 32'h3F);
        drive(mk(LOAD, 2, 1, 0), 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b1);
        cycle();
        load_pkt = bus.instruction_out;
        checks++;
        if (load_pkt[63:32] !== 32'h3F || load_pkt[79:64] !== mk(LOAD, 2, 1, 0)) begin
            errors++; $display("FAIL load_pkt got %h want dat1 3f", load_pkt);
        end
        drive(mk(ADD, 3, 1, 1), 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (bus.stall_fetch !== 1'b1) begin
            errors++; $display("FAIL load_stall got %b want 1", bus.stall_fetch);
        end
        cycle();
        checks++;
        if (bus.instruction_out !== load_pkt) begin
            errors++; $display("FAIL load_hold got %h want %h", bus.instruction_out, load_pkt);
        end
        bus.backpressure_exec_load = 1'b1;
        cycle();
        checks++;
        if (bus.instruction_out[79:64] !== mk(ADD, 3, 1, 1) || bus.instruction_out[31:0] !== 32'h3F) begin
            errors++; $display("FAIL load_release got %h want add r3,r1,r1", bus.instruction_out);
        end
    endtask

    task automatic test_jump_flush();
        write_reg(7, 32'h20);
        drive(mk(JMP, 7, 0, 0), 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b1);
        cycle();
        checks++;
        if (bus.instruction_out[63:32] !== 32'h20 || bus.instruction_out[31:0] !== 32'd0) begin
            errors++; $display("FAIL jmp_pkt got %h want dat1 20 dat2 0", bus.instruction_out);
        end
        drive(mk(OR_, 1, 2, 3), 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
        cycle();
        checks++;
        if (bus.instruction_out !== NOP_PKT) begin
            errors++; $display("FAIL jmp_flush got %h want %h", bus.instruction_out, NOP_PKT);
        end
        idle();
        cycle();
        checks++;
        if (bus.instruction_out !== NOP_PKT) begin
            errors++; $display("FAIL jmp_no_replay got %h want %h", bus.instruction_out, NOP_PKT);
        end
    endtask

    task automatic test_flush_backpressure();
        drive(mk(ADD, 1, 2, 3), 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b1);
        cycle();
        drive(mk(SUB, 1, 2, 3), 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.stall_fetch !== 1'b0) begin
            errors++; $display("FAIL flush_bp_stall got %b want 0", bus.stall_fetch);
        end
        cycle();
        checks++;
        if (bus.instruction_out !== NOP_PKT) begin
            errors++; $display("FAIL flush_bp_out got %h want %h", bus.instruction_out, NOP_PKT);
        end
    endtask

    task automatic test_reset_mid_run();
        write_reg(3, 32'h55);
        drive(mk(ADD, 0, 3, 3), 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b1);
        cycle();
        checks++;
        if (bus.instruction_out[63:32] !== 32'h55) begin
            errors++; $display("FAIL pre_reset got %h want 55", bus.instruction_out[63:32]);
        end
        #3;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
        exp_out = NOP_PKT;
        #1;
        checks++;
        if (bus.instruction_out !== NOP_PKT) begin
            errors++; $display("FAIL async_reset got %h want %h", bus.instruction_out, NOP_PKT);
        end
        cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if (bus.instruction_out[63:32] !== 32'd0 || bus.instruction_out[31:0] !== 32'd0) begin
            errors++; $display("FAIL r3_cleared got %h want 0", bus.instruction_out[63:0]);
        end
    endtask

    task automatic test_random();
        logic [6:0]  op;
        logic        bp, jmp, want_stall;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else op = op_table[$urandom_range(0, 13)];
            bp  = ($urandom_range(0, 9) != 0);
            jmp = ($urandom_range(0, 9) != 0);
            drive({op, 9'($urandom)}, 1'($urandom), $urandom_range(0, 7), $urandom,
                  1'($urandom), $urandom_range(0, 7), $urandom, bp, jmp);
            want_stall = !bp && jmp;
            #1;
            checks++;
            if (bus.stall_fetch !== want_stall) begin
                errors++; $display("FAIL rand_stall n=%0d got %b want %b", n, bus.stall_fetch, want_stall);
            end
            cycle();
            checks++;
            if (bus.instruction_out !== exp_out) begin
                errors++; $display("FAIL rand_pkt n=%0d got %h want %h", n, bus.instruction_out, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_through();
        test_fwd_priority();
        test_load_hold();
        test_jump_flush();
        test_flush_backpressure();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
